// File: rtl/demux_tdm_1a4_pkg.sv
// demux_tdm_1a4_pkg
//   Shared definitions for the four-slot TDM demultiplexer: the FSM state
//   encoding, the number of slots per frame and the width of the slot index.
//   No ports; imported by demux_tdm_1a4 and slot_counter.
package demux_tdm_1a4_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

endpackage

// File: rtl/demux_tdm_1a4_slot_counter.sv
// slot_counter
//   Index of the next expected slot in a TDM frame. It mirrors the select
//   input of the multiplexer on the sending side.
//   Ports:
//     clk      - clock, rising edge
//     rst_n    - synchronous active-low reset, clears the index to 0
//     load_one - a start-of-frame beat was taken as slot 0, so slot 1 is next
//     advance  - a non-sof beat was taken, step to the next slot
//     slot     - current slot index
module slot_counter
  import demux_tdm_1a4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_one,
  input  logic              advance,
  output logic [SLOT_W-1:0] slot
);

  logic [SLOT_W-1:0] slot_d;
  logic [SLOT_W-1:0] slot_q;

  // The final slot wraps explicitly so the counter is correct even if
  // NUM_SLOTS is not a power of two. A sof beat takes priority over a step.
  always_comb begin
    slot_d = slot_q;
    if (load_one) begin
      slot_d = SLOT_W'(1);
    end else if (advance) begin
      if (slot_q == SLOT_W'(NUM_SLOTS - 1)) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/demux_tdm_1a4.sv
// demux_tdm_1a4
//   Splits a time-multiplexed stream of four slots per frame onto four
//   registered channel outputs. Slots 0..2 are collected in shadow
//   registers; on the slot-3 beat all four channels load together, so a
//   partial or aborted frame never reaches the outputs.
//   Parameter:
//     WIDTH       - data width of din and A..D
//   Ports:
//     clk         - clock, rising edge
//     rst_n       - synchronous active-low reset
//     din         - multiplexed data
//     din_valid   - din carries a slot this cycle
//     sof         - marks slot 0 (only meaningful with din_valid)
//     A, B, C, D  - channel outputs for slots 0..3
//     frame_valid - one-cycle pulse when A..D update
//     frame_err   - one-cycle pulse when a frame is aborted by an early sof
//     slot        - next expected slot index
//     frame_cnt   - 8-bit count of completed frames, wrapping
//                   (present only when DEMUX_FRAME_COUNT_EN is defined)
module demux_tdm_1a4
  import demux_tdm_1a4_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_valid,
  input  logic              sof,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  output logic [WIDTH-1:0]  C,
  output logic [WIDTH-1:0]  D,
  output logic              frame_valid,
  output logic              frame_err,
  output logic [SLOT_W-1:0] slot
`ifdef DEMUX_FRAME_COUNT_EN
  ,
  output logic [7:0]        frame_cnt
`endif
);

  state_e state_d, state_q;

  // Slot 3 comes straight from din, so only slots 0..2 need shadowing.
  logic [NUM_SLOTS-2:0][WIDTH-1:0] shadow_d, shadow_q;
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q, c_d, c_q, d_d, d_q;
  logic frame_valid_d, frame_valid_q;
  logic frame_err_d, frame_err_q;
  logic slot_load_one;
  logic slot_advance;

  slot_counter u_slot_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_one (slot_load_one),
    .advance  (slot_advance),
    .slot     (slot)
  );

  // Next-state logic. Cycles without din_valid keep every register and only
  // let the pulses fall back to 0. In RECV the slot index is always 1..3,
  // so a sof there always aborts a partial frame and restarts at slot 0.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    d_d           = d_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    slot_load_one = 1'b0;
    slot_advance  = 1'b0;

    if (din_valid) begin
      case (state_q)
        IDLE: begin
          if (sof) begin
            shadow_d[0]   = din;
            slot_load_one = 1'b1;
            state_d       = RECV;
          end
        end
        RECV: begin
          if (sof) begin
            frame_err_d   = 1'b1;
            shadow_d[0]   = din;
            slot_load_one = 1'b1;
          end else if (slot == SLOT_W'(NUM_SLOTS - 1)) begin
            a_d           = shadow_q[0];
            b_d           = shadow_q[1];
            c_d           = shadow_q[2];
            d_d           = din;
            frame_valid_d = 1'b1;
            slot_advance  = 1'b1;
            state_d       = IDLE;
          end else begin
            case (slot)
              SLOT_W'(1): shadow_d[1] = din;
              SLOT_W'(2): shadow_d[2] = din;
              default:    shadow_d[0] = din;
            endcase
            slot_advance = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      d_q           <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      d_q           <= d_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign C           = c_q;
  assign D           = d_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

`ifdef DEMUX_FRAME_COUNT_EN
  logic [7:0] frame_cnt_d, frame_cnt_q;

  // Counts in step with the frame_valid pulse so both appear together;
  // 8-bit arithmetic gives the wrap from 255 to 0.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_valid_d) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_demux_tdm_1a4.sv
// tb_demux_tdm_1a4
//   Self-checking bench for demux_tdm_1a4. Expected frames are pushed onto a
//   queue when their slot-3 beat is driven and popped when frame_valid is
//   seen. Define DEMUX_FRAME_COUNT_EN to also exercise frame_cnt.
module tb_demux_tdm_1a4;

  localparam int W = 3;
`ifdef DEMUX_FRAME_COUNT_EN
  localparam int NUM_B2B = 257;
`else
  localparam int NUM_B2B = 6;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         sof;
  logic [W-1:0] A, B, C, D;
  logic         frame_valid;
  logic         frame_err;
  logic [1:0]   slot;
`ifdef DEMUX_FRAME_COUNT_EN
  logic [7:0]   frame_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;
  logic [4*W-1:0] exp_q[$];
  logic [4*W-1:0] exp_frame;
  logic [4*W-1:0] prev_frame;

  demux_tdm_1a4 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .A           (A),
    .B           (B),
    .C           (C),
    .D           (D),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .slot        (slot)
`ifdef DEMUX_FRAME_COUNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One clock with the given inputs; returns #1 after the rising edge.
  task automatic drive_beat(input logic [W-1:0] d, input logic s, input logic v);
    din       = d;
    sof       = s;
    din_valid = v;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_beat('0, 1'b0, 1'b0);
    drive_beat('0, 1'b0, 1'b0);
    rst_n = 1'b1;
    model_cnt = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({A, B, C, D} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_abcd: got %h want 0", {A, B, C, D});
    end
    n_checks++;
    if ({frame_valid, frame_err, slot} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got fv=%b fe=%b slot=%0d want 0,0,0", frame_valid, frame_err, slot);
    end
`ifdef DEMUX_FRAME_COUNT_EN
    n_checks++;
    if (frame_cnt !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_cnt: got %0d want 0", frame_cnt);
    end
`endif
  endtask

  task automatic test_basic();
    logic [W-1:0] data [4];
    data = '{3'b001, 3'b100, 3'b101, 3'b110};
    prev_frame = {A, B, C, D};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back({data[0], data[1], data[2], data[3]});
      drive_beat(data[i], i == 0, 1'b1);
      if (i < 3) begin
        n_checks++;
        if (slot !== 2'(i + 1) || frame_valid !== 1'b0 || {A, B, C, D} !== prev_frame) begin
          n_fail++;
          $display("[TB] FAIL basic_beat%0d: got slot=%0d fv=%b abcd=%h want slot=%0d fv=0 abcd=%h",
                   i, slot, frame_valid, {A, B, C, D}, i + 1, prev_frame);
        end
      end
    end
    n_checks++;
    if (frame_valid !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL basic_fv: got fv=%b queued=%0d want fv=1", frame_valid, exp_q.size());
    end else begin
      exp_frame = exp_q.pop_front();
      model_cnt++;
      n_checks++;
      if ({A, B, C, D} !== exp_frame || slot !== 2'd0) begin
        n_fail++;
        $display("[TB] FAIL basic_data: got abcd=%h slot=%0d want abcd=%h slot=0", {A, B, C, D}, slot, exp_frame);
      end
    end
    drive_beat('0, 1'b0, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_pulse_len: got fv=%b want 0", frame_valid);
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] data [4];
    int pulses;
    data = '{3'b001, 3'b100, 3'b101, 3'b110};
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back({data[0], data[1], data[2], data[3]});
      drive_beat(data[i], i == 0, 1'b1);
      if (frame_valid === 1'b1) pulses++;
      if (i == 3 && frame_valid === 1'b1 && exp_q.size() != 0) begin
        exp_frame = exp_q.pop_front();
        model_cnt++;
        n_checks++;
        if ({A, B, C, D} !== exp_frame || slot !== 2'd0) begin
          n_fail++;
          $display("[TB] FAIL gaps_data: got abcd=%h slot=%0d want abcd=%h slot=0", {A, B, C, D}, slot, exp_frame);
        end
      end
      for (int g = 0; g < 2; g++) begin
        drive_beat(3'b111, 1'b1, 1'b0);
        if (frame_valid === 1'b1) pulses++;
        n_checks++;
        if (slot !== 2'((i + 1) % 4)) begin
          n_fail++;
          $display("[TB] FAIL gaps_slot_hold: got %0d want %0d", slot, (i + 1) % 4);
        end
      end
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("[TB] FAIL gaps_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_abort();
    prev_frame = {A, B, C, D};
    drive_beat(3'b001, 1'b1, 1'b1);
    drive_beat(3'b100, 1'b0, 1'b1);
    drive_beat(3'b111, 1'b1, 1'b1);
    n_checks++;
    if (frame_err !== 1'b1 || slot !== 2'd1 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL abort_err: got fe=%b slot=%0d fv=%b want fe=1 slot=1 fv=0", frame_err, slot, frame_valid);
    end
    drive_beat(3'b010, 1'b0, 1'b1);
    n_checks++;
    if (frame_err !== 1'b0 || {A, B, C, D} !== prev_frame) begin
      n_fail++;
      $display("[TB] FAIL abort_hold: got fe=%b abcd=%h want fe=0 abcd=%h", frame_err, {A, B, C, D}, prev_frame);
    end
    drive_beat(3'b011, 1'b0, 1'b1);
    n_checks++;
    if ({A, B, C, D} !== prev_frame) begin
      n_fail++;
      $display("[TB] FAIL abort_hold2: got abcd=%h want %h", {A, B, C, D}, prev_frame);
    end
    exp_q.push_back({3'b111, 3'b010, 3'b011, 3'b000});
    drive_beat(3'b000, 1'b0, 1'b1);
    n_checks++;
    if (frame_valid !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL abort_fv: got fv=%b want 1", frame_valid);
    end else begin
      exp_frame = exp_q.pop_front();
      model_cnt++;
      n_checks++;
      if ({A, B, C, D} !== exp_frame) begin
        n_fail++;
        $display("[TB] FAIL abort_data: got %h want %h", {A, B, C, D}, exp_frame);
      end
    end
  endtask

  task automatic test_idle_discard();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_beat(3'b111, 1'b0, 1'b1);
      n_checks++;
      if (slot !== 2'd0 || frame_valid !== 1'b0 || frame_err !== 1'b0 || {A, B, C, D} !== '0) begin
        n_fail++;
        $display("[TB] FAIL idle_discard%0d: got slot=%0d fv=%b fe=%b abcd=%h want 0,0,0,0",
                 i, slot, frame_valid, frame_err, {A, B, C, D});
      end
    end
    drive_beat(3'b101, 1'b1, 1'b0);
    n_checks++;
    if (slot !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL sof_no_valid_idle: got slot=%0d want 0", slot);
    end
    drive_beat(3'b101, 1'b1, 1'b1);
    drive_beat(3'b110, 1'b1, 1'b0);
    n_checks++;
    if (slot !== 2'd1 || frame_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL sof_no_valid_recv: got slot=%0d fe=%b want slot=1 fe=0", slot, frame_err);
    end
  endtask

  task automatic test_reset_midframe();
    logic [W-1:0] data [4];
    data = '{3'b010, 3'b001, 3'b111, 3'b100};
    do_reset();
    for (int i = 0; i < 4; i++) drive_beat(data[i], i == 0, 1'b1);
    drive_beat(3'b101, 1'b1, 1'b1);
    drive_beat(3'b110, 1'b0, 1'b1);
    drive_beat(3'b011, 1'b0, 1'b1);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_beat(3'b000, 1'b0, 1'b1);
      n_checks++;
      if (frame_valid !== 1'b0 || frame_err !== 1'b0 || slot !== 2'd0 || {A, B, C, D} !== '0) begin
        n_fail++;
        $display("[TB] FAIL midreset_%0d: got fv=%b fe=%b slot=%0d abcd=%h want all 0",
                 i, frame_valid, frame_err, slot, {A, B, C, D});
      end
    end
    rst_n = 1'b1;
    model_cnt = 0;
    data = '{3'b110, 3'b101, 3'b100, 3'b011};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back({data[0], data[1], data[2], data[3]});
      drive_beat(data[i], i == 0, 1'b1);
      if (i == 0) begin
        n_checks++;
        if (frame_err !== 1'b0 || slot !== 2'd1) begin
          n_fail++;
          $display("[TB] FAIL midreset_restart: got fe=%b slot=%0d want fe=0 slot=1", frame_err, slot);
        end
      end
    end
    n_checks++;
    if (frame_valid !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_fv: got fv=%b want 1", frame_valid);
    end else begin
      exp_frame = exp_q.pop_front();
      model_cnt++;
      n_checks++;
      if ({A, B, C, D} !== exp_frame) begin
        n_fail++;
        $display("[TB] FAIL midreset_data: got %h want %h", {A, B, C, D}, exp_frame);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d [4];
    do_reset();
    for (int f = 0; f < NUM_B2B; f++) begin
      for (int i = 0; i < 4; i++) d[i] = W'($urandom_range(0, (1 << W) - 1));
      for (int i = 0; i < 4; i++) begin
        if (i == 3) exp_q.push_back({d[0], d[1], d[2], d[3]});
        drive_beat(d[i], i == 0, 1'b1);
        if (i < 3) begin
          n_checks++;
          if (frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_quiet f%0d b%0d: got fv=%b fe=%b want 0,0", f, i, frame_valid, frame_err);
          end
        end
      end
      n_checks++;
      if (frame_valid !== 1'b1 || exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL b2b_fv f%0d: got fv=%b want 1", f, frame_valid);
      end else begin
        exp_frame = exp_q.pop_front();
        model_cnt++;
        n_checks++;
        if ({A, B, C, D} !== exp_frame) begin
          n_fail++;
          $display("[TB] FAIL b2b_data f%0d: got %h want %h", f, {A, B, C, D}, exp_frame);
        end
`ifdef DEMUX_FRAME_COUNT_EN
        n_checks++;
        if (frame_cnt !== 8'(model_cnt)) begin
          n_fail++;
          $display("[TB] FAIL b2b_cnt f%0d: got %0d want %0d", f, frame_cnt, model_cnt % 256);
        end
`endif
      end
    end
`ifdef DEMUX_FRAME_COUNT_EN
    n_checks++;
    if (frame_cnt !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL b2b_final_cnt: got %0d want 1", frame_cnt);
    end
`endif
    drive_beat('0, 1'b0, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL b2b_end: got fv=%b pending=%0d want 0,0", frame_valid, exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    sof       = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_abort();
    test_idle_discard();
    test_reset_midframe();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_tdm_1a4.md
DEMUX_TDM_1A4 -- requirements
Module: demux_tdm_1a4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, giving the data width of every data port.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 The block SHALL have port din, input, WIDTH bits: the time-multiplexed data stream.
REQ-005 The block SHALL have port din_valid, input, 1 bit: din holds a valid slot this cycle.
REQ-006 The block SHALL have port sof, input, 1 bit: start of frame; qualified by din_valid, it marks slot 0.
REQ-007 The block SHALL have ports A, B, C and D, each output, WIDTH bits: registered channel outputs for slots 0, 1, 2 and 3.
REQ-008 The block SHALL have port frame_valid, output, 1 bit: one-cycle pulse when A..D update.
REQ-009 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-010 The block SHALL have port slot, output, 2 bits: the next expected slot index, equivalent to the selector of the sending multiplexer.

Function
REQ-011 The block SHALL implement two states: IDLE (waiting for sof) and RECV (collecting slots).
REQ-012 A valid beat is a cycle with din_valid=1; cycles with din_valid=0 SHALL change no state, no slot and no output except clearing the pulses.
REQ-013 In IDLE, a valid beat with sof=1 SHALL store din as slot 0, set slot=1 and enter RECV; a valid beat with sof=0 SHALL be discarded.
REQ-014 In RECV, a valid beat with sof=0 SHALL store din into the shadow register of the current slot and increment slot.
REQ-015 On the valid beat for slot 3, A..D SHALL load all four shadow values simultaneously (slot 3 taken directly from din), frame_valid SHALL be 1 for exactly the next cycle, slot SHALL wrap to 0 and the state SHALL return to IDLE.
REQ-016 A..D SHALL hold their values between frames; a partial frame SHALL never alter A..D.
REQ-017 If sof=1 arrives on a valid beat while in RECV with slot 1..3, frame_err SHALL pulse for one cycle, the partial frame SHALL be dropped, and that beat SHALL be stored as slot 0 of a new frame (slot=1, state RECV).
REQ-018 Latency: A..D and frame_valid SHALL be visible one clock after the rising edge that samples slot 3.
REQ-019 Back-to-back frames (a slot-3 beat followed immediately by a sof beat) SHALL be accepted with no idle cycle.
REQ-020 sof=1 with din_valid=0 SHALL be ignored.

Reset
REQ-021 When rst_n=0 at a rising edge, the block SHALL enter IDLE and set A=B=C=D=0, shadow registers=0, slot=0, frame_valid=0, frame_err=0 and frame_cnt=0 where present.
REQ-022 Reset asserted mid-frame SHALL discard the partial frame with no frame_valid or frame_err pulse.

Configuration
REQ-023 When macro DEMUX_FRAME_COUNT_EN is defined, the block SHALL add output frame_cnt (8 bits), which increments on each frame_valid pulse and wraps from 255 to 0.
REQ-024 When DEMUX_FRAME_COUNT_EN is undefined, the frame_cnt port and its logic SHALL be absent, with all other behaviour unchanged.

Structure
REQ-025 A shared package SHALL hold the state encoding (IDLE=0, RECV=1), the constant NUM_SLOTS=4 and the slot index width of 2.
REQ-026 The slot counter with its wrap logic SHALL be a sub-module named slot_counter; FSM, shadow and output registers SHALL stay in demux_tdm_1a4.

Verification
REQ-027 Reset, then valid beats din=001(sof),100,101,110 -> next cycle A=001, B=100, C=101, D=110, frame_valid=1 for one cycle, slot=0.
REQ-028 The same frame with din_valid=0 for 2 cycles between each beat -> identical A..D, a single frame_valid pulse, and slot holding its value during gaps.
REQ-029 Frame 001,100 then sof with 111 followed by 010,011,000 -> frame_err pulse on the sof beat, then A=111, B=010, C=011, D=000, and A..D unchanged before the completed frame.
REQ-030 Valid beats with sof=0 in IDLE (din=111 x3) -> slot stays 0, no pulses, A..D remain 0.
REQ-031 rst_n=0 after slot 2 of a frame, then a full new frame -> no pulse during reset, all outputs 0, and the next frame decodes correctly.
REQ-032 With DEMUX_FRAME_COUNT_EN, 257 back-to-back frames -> a frame_valid pulse every 4 cycles and final frame_cnt=1.
